// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: round-robin front end for a shared master-slave JK bank.
// Two requesters issue hold/clear/set/toggle commands with a bit mask. One is
// granted, and its j/k vectors are driven for a single cycle. After the slave
// stage settles, the bank is read back and the granted requester gets a done pulse.
module jk_bank_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_mask,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_mask,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  input  logic [WIDTH-1:0] q_in,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] rdata,
  output logic             busy
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SETTLE, S_RESP} state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_gid;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_jk_j;
  logic [WIDTH-1:0] r_jk_k;
  logic [WIDTH-1:0] r_rdata;
  logic             r_done0;
  logic             r_done1;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_idle;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_mask;

  // Arbitration: a lone requester wins; on contention, the one not served last wins.
  always_comb begin
    w_idle = (r_state == S_IDLE);
    w_gnt0 = req0_valid & (~req1_valid | r_last_grant);
    w_gnt1 = req1_valid & (~req0_valid | ~r_last_grant);
    w_op   = w_gnt1 ? req1_op   : req0_op;
    w_mask = w_gnt1 ? req1_mask : req0_mask;
  end

  assign req0_ready = w_idle & w_gnt0;
  assign req1_ready = w_idle & w_gnt1;
  assign jk_j       = r_jk_j;
  assign jk_k       = r_jk_k;
  assign rdata      = r_rdata;
  assign done0      = r_done0;
  assign done1      = r_done1;
  assign busy       = ~w_idle;

  // Sequencer FSM. j/k and done are registered one-cycle pulses that default to 0.
  // j/k are loaded on the accept edge so that they are valid exactly during APPLY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_gid        <= 1'b0;
      r_cnt        <= '0;
      r_jk_j       <= '0;
      r_jk_k       <= '0;
      r_rdata      <= '0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
    end else begin
      r_jk_j  <= '0;
      r_jk_k  <= '0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_gid        <= w_gnt1;
            r_last_grant <= w_gnt1;
            r_jk_j       <= w_mask & {WIDTH{w_op[1]}};
            r_jk_k       <= w_mask & {WIDTH{w_op[0]}};
            r_state      <= S_APPLY;
          end
        end
        S_APPLY: begin
          r_cnt   <= CW'(SETTLE_CYCLES - 1);
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_cnt == '0) r_state <= S_RESP;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_RESP: begin
          r_rdata <= q_in;
          r_done0 <= ~r_gid;
          r_done1 <= r_gid;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
